// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, immediate formats,
// the ID/EX pipeline record and the immediate/ALU decode helpers.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
      AluSrl, AluSra, AluOr, AluAnd, AluPassB
   } alu_op_t;

   typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_t;

   typedef struct packed {
      logic            valid;
      logic [31:0]     pc;
      logic [XLEN-1:0] rs1_val;
      logic [XLEN-1:0] rs2_val;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      alu_op_t         alu_op;
      logic            alu_src_imm;
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      mem_size;
      logic            reg_write;
      logic            illegal;
   } id_ex_t;

   function automatic logic [XLEN-1:0] gen_imm(logic [31:0] instr, imm_fmt_t fmt);
      logic [XLEN-1:0] imm;
      case (fmt)
         ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
         ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         ImmU:    imm = {instr[31:12], 12'b0};
         ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // is_reg selects SUB for funct3=000; shifts use funct7[5] in both forms.
   function automatic alu_op_t alu_decode(logic [2:0] funct3, logic funct7_5, logic is_reg);
      alu_op_t op;
      unique case (funct3)
         3'b000: op = (is_reg && funct7_5) ? AluSub : AluAdd;
         3'b001: op = AluSll;
         3'b010: op = AluSlt;
         3'b011: op = AluSltu;
         3'b100: op = AluXor;
         3'b101: op = funct7_5 ? AluSra : AluSrl;
         3'b110: op = AluOr;
         3'b111: op = AluAnd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, write-back and ID/EX signal bundle around the decode stage.
interface decode_stage_if;
   import riscv_pkg::*;

   logic            if_valid;
   logic [31:0]     if_instr;
   logic [31:0]     if_pc;
   logic            flush;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   logic            stall;
   logic            id_valid;
   logic [31:0]     id_pc;
   logic [XLEN-1:0] id_rs1_val;
   logic [XLEN-1:0] id_rs2_val;
   logic [XLEN-1:0] id_imm;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   alu_op_t         id_alu_op;
   logic            id_alu_src_imm;
   logic            id_mem_read;
   logic            id_mem_write;
   logic [2:0]      id_mem_size;
   logic            id_reg_write;
   logic            id_illegal;

   modport master (
      output if_valid, if_instr, if_pc, flush, wb_we, wb_rd, wb_data,
      input  stall, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_op, id_alu_src_imm, id_mem_read, id_mem_write, id_mem_size,
             id_reg_write, id_illegal
   );

   modport slave (
      input  if_valid, if_instr, if_pc, flush, wb_we, wb_rd, wb_data,
      output stall, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_op, id_alu_src_imm, id_mem_read, id_mem_write, id_mem_size,
             id_reg_write, id_illegal
   );

endinterface

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two async read ports with write-through bypass,
// one sync write port, x0 hardwired to zero.
module regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] regs_q [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = regs_q[raddr1];
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (we && (waddr == raddr1)) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = regs_q[raddr2];
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (we && (waddr == raddr2)) begin
         rdata2 = wdata;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: IF/ID register, register file, control/immediate decode,
// load-use hazard detection and the ID/EX register.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int unsigned NREGS    = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);

   logic            ifid_valid_q;
   logic [31:0]     ifid_instr_q;
   logic [31:0]     ifid_pc_q;
   id_ex_t          idex_q, idex_d, dec;
   imm_fmt_t        imm_fmt;
   logic            use_rs1, use_rs2, write_rd;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            stall;

   assign rd  = ifid_instr_q[11:7];
   assign rs1 = ifid_instr_q[19:15];
   assign rs2 = ifid_instr_q[24:20];

   regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (bus.wb_we),
      .waddr  (bus.wb_rd),
      .wdata  (bus.wb_data),
      .raddr1 (dec.rs1),
      .raddr2 (dec.rs2),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val)
   );

   // Operand values are merged into idex_d, keeping the regfile address path acyclic.
   always_comb begin
      dec         = '0;
      dec.valid   = ifid_valid_q;
      dec.pc      = ifid_pc_q;
      dec.alu_op  = AluAdd;
      imm_fmt     = ImmNone;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      write_rd    = 1'b0;
      case (ifid_instr_q[6:0])
         OpcOp: begin
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            write_rd   = 1'b1;
            dec.alu_op = alu_decode(ifid_instr_q[14:12], ifid_instr_q[30], 1'b1);
         end
         OpcOpImm: begin
            use_rs1         = 1'b1;
            write_rd        = 1'b1;
            imm_fmt         = ImmI;
            dec.alu_src_imm = 1'b1;
            dec.alu_op      = alu_decode(ifid_instr_q[14:12], ifid_instr_q[30], 1'b0);
         end
         OpcLoad: begin
            use_rs1         = 1'b1;
            write_rd        = 1'b1;
            imm_fmt         = ImmI;
            dec.alu_src_imm = 1'b1;
            dec.mem_read    = 1'b1;
            dec.mem_size    = ifid_instr_q[14:12];
         end
         OpcStore: begin
            use_rs1         = 1'b1;
            use_rs2         = 1'b1;
            imm_fmt         = ImmS;
            dec.alu_src_imm = 1'b1;
            dec.mem_write   = 1'b1;
            dec.mem_size    = ifid_instr_q[14:12];
         end
         OpcBranch: begin
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            imm_fmt    = ImmB;
            dec.alu_op = AluSub;
         end
         OpcLui: begin
            write_rd        = 1'b1;
            imm_fmt         = ImmU;
            dec.alu_src_imm = 1'b1;
            dec.alu_op      = AluPassB;
         end
         OpcAuipc, OpcJal: begin
            write_rd        = 1'b1;
            imm_fmt         = (ifid_instr_q[6:0] == OpcJal) ? ImmJ : ImmU;
            dec.alu_src_imm = 1'b1;
         end
         OpcJalr: begin
            use_rs1         = 1'b1;
            write_rd        = 1'b1;
            imm_fmt         = ImmI;
            dec.alu_src_imm = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.rs1       = use_rs1 ? rs1 : '0;
      dec.rs2       = use_rs2 ? rs2 : '0;
      dec.rd        = write_rd ? rd : '0;
      dec.reg_write = write_rd && (rd != '0);
      dec.imm       = gen_imm(ifid_instr_q, imm_fmt);
   end

   // Only sources the format actually reads can create a load-use hazard.
   always_comb begin
      stall = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) && ifid_valid_q &&
              ((use_rs1 && (rs1 == idex_q.rd)) || (use_rs2 && (rs2 == idex_q.rd)));
      if (bus.flush) begin
         stall = 1'b0;
      end
   end

   always_comb begin
      idex_d    = '0;
      idex_d.pc = RESET_PC;
      if (!bus.flush && !stall && ifid_valid_q) begin
         idex_d         = dec;
         idex_d.rs1_val = rs1_val;
         idex_d.rs2_val = rs2_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
      end else if (!stall) begin
         ifid_valid_q <= bus.if_valid;
         ifid_instr_q <= bus.if_instr;
         ifid_pc_q    <= bus.if_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q    <= '0;
         idex_q.pc <= RESET_PC;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign bus.stall          = stall;
   assign bus.id_valid       = idex_q.valid;
   assign bus.id_pc          = idex_q.pc;
   assign bus.id_rs1_val     = idex_q.rs1_val;
   assign bus.id_rs2_val     = idex_q.rs2_val;
   assign bus.id_imm         = idex_q.imm;
   assign bus.id_rs1         = idex_q.rs1;
   assign bus.id_rs2         = idex_q.rs2;
   assign bus.id_rd          = idex_q.rd;
   assign bus.id_alu_op      = idex_q.alu_op;
   assign bus.id_alu_src_imm = idex_q.alu_src_imm;
   assign bus.id_mem_read    = idex_q.mem_read;
   assign bus.id_mem_write   = idex_q.mem_write;
   assign bus.id_mem_size    = idex_q.mem_size;
   assign bus.id_reg_write   = idex_q.reg_write;
   assign bus.id_illegal     = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, bypass, load-use stall, flush,
// x0 protection and mid-stream reset, all against hand-computed values.
module tb_decode_stage;
   import riscv_pkg::*;

   localparam logic [31:0] RstPc     = 32'h0000_0040;
   localparam logic [31:0] InAddi    = 32'h3e80_0093;  // addi x1,x0,1000
   localparam logic [31:0] InAddX2   = 32'h0010_8133;  // add x2,x1,x1
   localparam logic [31:0] InSw      = 32'h0010_2023;  // sw x1,0(x0)
   localparam logic [31:0] InLb      = 32'h0000_0103;  // lb x2,0(x0)
   localparam logic [31:0] InAddX3   = 32'h0021_01b3;  // add x3,x2,x2
   localparam logic [31:0] InAddX4X1 = 32'h0000_8233;  // add x4,x1,x0
   localparam logic [31:0] InAddX5X0 = 32'h0000_02b3;  // add x5,x0,x0

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   decode_stage_if bus ();

   decode_stage #(
      .NREGS    (32),
      .RESET_PC (RstPc)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decode table: instruction, immediate, ALU op, illegal, reg_write.
   logic [31:0] v_instr [7] = '{32'h1234_5337, 32'hfe20_8ee3, 32'h0080_00ef, 32'h0000_000b,
                                32'h4030_d093, 32'h4031_00b3, 32'hfff0_0013};
   logic [31:0] v_imm   [7] = '{32'h1234_5000, 32'hffff_fffc, 32'h0000_0008, 32'h0,
                                32'h0000_0403, 32'h0, 32'hffff_ffff};
   logic [3:0]  v_op    [7] = '{4'd10, 4'd1, 4'd0, 4'd0, 4'd7, 4'd1, 4'd0};
   logic        v_ill   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic        v_rw    [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      bus.if_valid = v;
      bus.if_instr = instr;
      bus.if_pc    = pc;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      bus.flush   = 1'b0;
      bus.wb_we   = 1'b0;
      bus.wb_rd   = '0;
      bus.wb_data = '0;
      feed(1'b0, 32'h0, 32'h0);
      step();
      step();
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_valid", 32'(bus.id_valid), 32'd0);
      check("rst_pc", bus.id_pc, RstPc);
      check("rst_regwrite", 32'(bus.id_reg_write), 32'd0);
      reset = 1'b0;

      // addi, then add reading x1 through the write-through bypass
      feed(1'b1, InAddi, 32'h100);
      step();
      feed(1'b1, InAddX2, 32'h104);
      step();
      check("addi_valid", 32'(bus.id_valid), 32'd1);
      check("addi_pc", bus.id_pc, 32'h100);
      check("addi_imm", bus.id_imm, 32'd1000);
      check("addi_rd", 32'(bus.id_rd), 32'd1);
      check("addi_op", 32'(bus.id_alu_op), 32'(AluAdd));
      check("addi_srcimm", 32'(bus.id_alu_src_imm), 32'd1);
      check("addi_rw", 32'(bus.id_reg_write), 32'd1);
      check("addi_mem", {30'd0, bus.id_mem_read, bus.id_mem_write}, 32'd0);
      check("addi_ill", 32'(bus.id_illegal), 32'd0);
      bus.wb_we   = 1'b1;
      bus.wb_rd   = 5'd1;
      bus.wb_data = 32'd1000;
      feed(1'b1, InSw, 32'h108);
      step();
      bus.wb_we = 1'b0;
      check("bypass_rs1", bus.id_rs1_val, 32'd1000);
      check("bypass_rs2", bus.id_rs2_val, 32'd1000);
      check("add_rd", 32'(bus.id_rd), 32'd2);
      check("add_srcimm", 32'(bus.id_alu_src_imm), 32'd0);

      feed(1'b1, InLb, 32'h10c);
      step();
      check("sw_memwrite", 32'(bus.id_mem_write), 32'd1);
      check("sw_rw", 32'(bus.id_reg_write), 32'd0);
      check("sw_imm", bus.id_imm, 32'd0);
      check("sw_size", 32'(bus.id_mem_size), 32'd2);
      check("sw_rs2val", bus.id_rs2_val, 32'd1000);

      // load-use: one stall cycle, one bubble, then the dependent add
      feed(1'b1, InAddX3, 32'h110);
      step();
      check("lb_memread", 32'(bus.id_mem_read), 32'd1);
      check("lb_rd", 32'(bus.id_rd), 32'd2);
      check("lu_stall", 32'(bus.stall), 32'd1);
      step();
      check("lu_bubble", 32'(bus.id_valid), 32'd0);
      check("lu_bubble_pc", bus.id_pc, RstPc);
      check("lu_stall_once", 32'(bus.stall), 32'd0);
      feed(1'b0, 32'h0, 32'h0);
      step();
      check("lu_add_valid", 32'(bus.id_valid), 32'd1);
      check("lu_add_pc", bus.id_pc, 32'h110);
      check("lu_add_rs1", 32'(bus.id_rs1), 32'd2);
      check("lu_add_rd", 32'(bus.id_rd), 32'd3);

      // flush during a load-use stall
      feed(1'b1, InLb, 32'h200);
      step();
      feed(1'b1, InAddX3, 32'h204);
      step();
      check("fl_pre_stall", 32'(bus.stall), 32'd1);
      bus.flush = 1'b1;
      feed(1'b1, InAddX4X1, 32'h208);
      step();
      bus.flush = 1'b0;
      check("fl_idex_bubble", 32'(bus.id_valid), 32'd0);
      check("fl_stall", 32'(bus.stall), 32'd0);
      feed(1'b0, 32'h0, 32'h0);
      step();
      check("fl_ifid_bubble", 32'(bus.id_valid), 32'd0);
      feed(1'b1, InAddX4X1, 32'h300);
      step();
      feed(1'b0, 32'h0, 32'h0);
      step();
      check("fl_x1_kept", bus.id_rs1_val, 32'd1000);

      // write to x0 must be ignored, including the bypass path
      feed(1'b1, InAddX5X0, 32'h400);
      step();
      bus.wb_we   = 1'b1;
      bus.wb_rd   = 5'd0;
      bus.wb_data = 32'd5;
      feed(1'b0, 32'h0, 32'h0);
      step();
      bus.wb_we = 1'b0;
      check("x0_bypass", bus.id_rs1_val, 32'd0);
      feed(1'b1, InAddX5X0, 32'h404);
      step();
      feed(1'b0, 32'h0, 32'h0);
      step();
      check("x0_read", bus.id_rs2_val, 32'd0);

      for (int k = 0; k < 7; k++) begin
         feed(1'b1, v_instr[k], 32'h500 + 32'(4 * k));
         step();
         feed(1'b0, 32'h0, 32'h0);
         step();
         check($sformatf("vec%0d_imm", k), bus.id_imm, v_imm[k]);
         check($sformatf("vec%0d_op", k), 32'(bus.id_alu_op), 32'(v_op[k]));
         check($sformatf("vec%0d_ill", k), 32'(bus.id_illegal), 32'(v_ill[k]));
         check($sformatf("vec%0d_rw", k), 32'(bus.id_reg_write), 32'(v_rw[k]));
      end

      // reset in the middle of a stall
      feed(1'b1, InLb, 32'h600);
      step();
      feed(1'b1, InAddX3, 32'h604);
      step();
      check("rs_pre_stall", 32'(bus.stall), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rs_valid", 32'(bus.id_valid), 32'd0);
      check("rs_pc", bus.id_pc, RstPc);
      check("rs_stall", 32'(bus.stall), 32'd0);
      check("rs_memread", 32'(bus.id_mem_read), 32'd0);
      check("rs_rd", 32'(bus.id_rd), 32'd0);
      feed(1'b1, InAddX4X1, 32'h700);
      step();
      feed(1'b0, 32'h0, 32'h0);
      step();
      check("rs_x1_cleared", bus.id_rs1_val, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
